spi_regfile: RTL and testbench

SPI_REGFILE -- requirements
Module: spi_regfile

---
 rtl/spi_regfile.sv | 211 +++++++++++++++++++++
 tb/tb_spi_regfile.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile.sv
// spi_regfile: SPI (mode 0) slave giving access to a bank of 8-bit registers.
//
// The first byte of a transaction is a command: bit7 selects write (1) or
// read (0), bits[6:0] give the start address. Every following complete byte
// is a data byte. On a write the byte is stored at the current address. On a
// read the register at the current address is shifted out MSB first. The
// address post-increments modulo 128 after each data byte. Addresses at or
// beyond NUM_REGS ignore writes and read as 8'h00.
//
// Ports:
//   clk     - system clock; all logic is on its rising edge
//   rst     - synchronous active-high reset
//   sclk    - SPI clock (asynchronous to clk)
//   ssel_n  - SPI select, active low (asynchronous to clk)
//   mosi    - SPI data in (asynchronous to clk)
//   miso    - SPI data out, registered
//   regs_o  - register contents, reg i at bits [8i+7:8i]
//   wr_stb  - one-clk pulse per committed register write
//   wr_addr - address of the last committed write
//   busy    - synchronised select is active

module spi_regfile #(
    parameter int                      NUM_REGS   = 4,
    parameter logic [NUM_REGS*8-1:0]   RESET_VALS = {8'h00, 8'h00, 8'h01, 8'h2A}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sclk,
    input  logic                    ssel_n,
    input  logic                    mosi,
    output logic                    miso,
    output logic [NUM_REGS*8-1:0]   regs_o,
    output logic                    wr_stb,
    output logic [6:0]              wr_addr,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    state_t state;
    state_t state_next;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic ssel_s1, ssel_s2, ssel_s3;
    logic mosi_s1, mosi_s2;

    logic sclk_rise, sclk_fall;
    logic ssel_fall, ssel_rise;

    logic rst_q;
    logic armed;

    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] tx_shift;
    logic       is_write;
    logic [6:0] addr;
    logic [7:0] regs [NUM_REGS];

    logic       byte_done;
    logic [7:0] rx_byte;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;

    // Two-flop synchronisers plus a history flop for edge detection.
    // Reset loads the idle bus levels so no spurious edge is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            ssel_s1 <= 1'b1;
            ssel_s2 <= 1'b1;
            ssel_s3 <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            ssel_s1 <= ssel_n;
            ssel_s2 <= ssel_s1;
            ssel_s3 <= ssel_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign ssel_fall = ~ssel_s2 & ssel_s3;
    assign ssel_rise = ssel_s2 & ~ssel_s3;

    assign busy = ~ssel_s2;

    // Because reset forces the select synchroniser high, a select still held
    // low through reset would look like a fresh falling edge once the
    // synchroniser refills. 'armed' only goes high after the first stage has
    // captured a real high level of ssel_n after reset, so a transaction cut
    // by reset is ignored until select is released and asserted again.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q <= 1'b1;
            armed <= 1'b0;
        end else begin
            rst_q <= 1'b0;
            if (!rst_q && ssel_s1) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ssel_fall && armed) state_next = CMD;
            CMD:     if (byte_done) state_next = DATA;
            DATA:    state_next = DATA;
            default: state_next = IDLE;
        endcase
        if (ssel_rise) begin
            state_next = IDLE;
        end
    end

    assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE);
    assign rx_byte   = {shift_in, mosi_s2};

    // At the end of the command byte the read address comes straight from the
    // byte being completed; at later byte boundaries it is the next address.
    assign rd_addr = (state == CMD) ? rx_byte[6:0] : addr + 7'd1;

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 7'(i)) begin
                rd_data = regs[i];
            end
        end
    end

    // Bit/byte datapath. miso is the MSB of tx_shift. A read byte is loaded
    // at the sclk rise that ends the previous byte, which puts its MSB on
    // miso before the next rise; the fall that immediately follows (bit_cnt
    // already wrapped to 0) must therefore not shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= 3'd0;
            shift_in <= 7'd0;
            tx_shift <= 8'h00;
            is_write <= 1'b0;
            addr     <= 7'd0;
            wr_stb   <= 1'b0;
            wr_addr  <= 7'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALS[8*i +: 8];
            end
        end else begin
            wr_stb <= 1'b0;
            if (state == IDLE || ssel_rise) begin
                bit_cnt  <= 3'd0;
                shift_in <= 7'd0;
                tx_shift <= 8'h00;
            end else if (sclk_rise) begin
                shift_in <= {shift_in[5:0], mosi_s2};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (state == CMD) begin
                        is_write <= rx_byte[7];
                        addr     <= rx_byte[6:0];
                        tx_shift <= rx_byte[7] ? 8'h00 : rd_data;
                    end else begin
                        if (is_write) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (addr == 7'(i)) begin
                                    regs[i] <= rx_byte;
                                    wr_stb  <= 1'b1;
                                    wr_addr <= addr;
                                end
                            end
                        end else begin
                            tx_shift <= rd_data;
                        end
                        addr <= addr + 7'd1;
                    end
                end
            end else if (sclk_fall && state == DATA && !is_write && bit_cnt != 3'd0) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    assign miso = tx_shift[7];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_o[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: self-checking bench for spi_regfile. An SPI master is
// modelled with tasks; a byte-level model of the register file predicts
// miso data, register contents, write strobes and the last write address.

module tb_spi_regfile;

    localparam int NUM_REGS = 4;
    localparam logic [NUM_REGS*8-1:0] RESET_VALS = {8'h00, 8'h00, 8'h01, 8'h2A};
    localparam int HALF = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  sclk = 1'b0;
    logic                  ssel_n = 1'b1;
    logic                  mosi = 1'b0;
    logic                  miso;
    logic [NUM_REGS*8-1:0] regs_o;
    logic                  wr_stb;
    logic [6:0]            wr_addr;
    logic                  busy;

    int passed = 0;
    int total = 0;
    int stb_count = 0;
    int exp_stb = 0;
    logic [6:0] exp_last_addr = 7'd0;

    logic [7:0] m_regs [NUM_REGS];
    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    logic [7:0] exp_rx [8];

    spi_regfile #(
        .NUM_REGS   (NUM_REGS),
        .RESET_VALS (RESET_VALS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .ssel_n  (ssel_n),
        .mosi    (mosi),
        .miso    (miso),
        .regs_o  (regs_o),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            stb_count++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NUM_REGS*8-1:0] exp_regs();
        logic [NUM_REGS*8-1:0] r;
        for (int i = 0; i < NUM_REGS; i++) begin
            r[8*i +: 8] = m_regs[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_regs[0] = 8'h2A;
        m_regs[1] = 8'h01;
        m_regs[2] = 8'h00;
        m_regs[3] = 8'h00;
        exp_last_addr = 7'd0;
    endtask

    // Byte-level view: nbytes complete bytes, the first being the command.
    task automatic model_xfer(input int nbytes);
        int  a;
        logic wr;
        for (int k = 0; k < 8; k++) exp_rx[k] = 8'h00;
        if (nbytes > 0) begin
            wr = tx_buf[0][7];
            a  = int'(tx_buf[0][6:0]);
            for (int k = 1; k < nbytes; k++) begin
                if (wr) begin
                    if (a < NUM_REGS) begin
                        m_regs[a] = tx_buf[k];
                        exp_stb++;
                        exp_last_addr = 7'(a);
                    end
                end else begin
                    exp_rx[k] = (a < NUM_REGS) ? m_regs[a] : 8'h00;
                end
                a = (a + 1) % 128;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
    endtask

    task automatic spi_start();
        @(negedge clk);
        ssel_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (HALF) @(negedge clk);
        ssel_n = 1'b1;
        mosi   = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // miso is captured just before the rising edge, as a mode-0 master does.
    task automatic spi_bit(input logic b, output logic m);
        @(negedge clk);
        mosi = b;
        repeat (HALF - 1) @(negedge clk);
        m    = miso;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        logic m;
        for (int j = 7; j >= 0; j--) begin
            spi_bit(b[j], m);
            r[j] = m;
        end
    endtask

    task automatic spi_xfer(input int nbytes, input int extra_bits, input logic [7:0] extra_val);
        logic m;
        spi_start();
        for (int k = 0; k < nbytes; k++) begin
            spi_byte(tx_buf[k], rx_buf[k]);
        end
        for (int j = 0; j < extra_bits; j++) begin
            spi_bit(extra_val[7-j], m);
        end
        spi_end();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (regs_o !== 32'h0000012A) $display("[TB] FAIL reset_regs: got %h expected %h", regs_o, 32'h0000012A);
        else passed++;
        total++;
        if (miso !== 1'b0) $display("[TB] FAIL reset_miso: got %b expected 0", miso);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        else passed++;
        total++;
        if (wr_stb !== 1'b0 || wr_addr !== 7'd0) $display("[TB] FAIL reset_wr: got stb=%b addr=%h expected 0/0", wr_stb, wr_addr);
        else passed++;
    endtask

    task automatic test_single_write();
        logic [7:0] r0, r1;
        tx_buf[0] = 8'h80;
        tx_buf[1] = 8'h55;
        model_xfer(2);
        spi_start();
        total++;
        if (busy !== 1'b1) $display("[TB] FAIL write_busy: got %b expected 1", busy);
        else passed++;
        spi_byte(tx_buf[0], r0);
        spi_byte(tx_buf[1], r1);
        spi_end();
        total++;
        if (r0 !== 8'h00 || r1 !== 8'h00) $display("[TB] FAIL write_miso: got %h %h expected 00 00", r0, r1);
        else passed++;
        total++;
        if (stb_count !== exp_stb) $display("[TB] FAIL write_stb_count: got %0d expected %0d", stb_count, exp_stb);
        else passed++;
        total++;
        if (wr_addr !== exp_last_addr) $display("[TB] FAIL write_addr: got %h expected %h", wr_addr, exp_last_addr);
        else passed++;
        total++;
        if (regs_o !== exp_regs()) $display("[TB] FAIL write_regs: got %h expected %h", regs_o, exp_regs());
        else passed++;
        total++;
        if (busy !== 1'b0) $display("[TB] FAIL write_busy_end: got %b expected 0", busy);
        else passed++;
    endtask

    task automatic test_burst_write();
        tx_buf[0] = 8'h82;
        tx_buf[1] = 8'h11;
        tx_buf[2] = 8'h22;
        tx_buf[3] = 8'h33;
        model_xfer(4);
        spi_xfer(4, 0, 8'h00);
        total++;
        if (stb_count !== exp_stb) $display("[TB] FAIL burst_stb_count: got %0d expected %0d", stb_count, exp_stb);
        else passed++;
        total++;
        if (wr_addr !== exp_last_addr) $display("[TB] FAIL burst_addr: got %h expected %h", wr_addr, exp_last_addr);
        else passed++;
        total++;
        if (regs_o !== exp_regs()) $display("[TB] FAIL burst_regs: got %h expected %h", regs_o, exp_regs());
        else passed++;
    endtask

    task automatic test_read();
        do_reset();
        tx_buf[0] = 8'h01;
        tx_buf[1] = 8'h00;
        tx_buf[2] = 8'h00;
        model_xfer(3);
        spi_xfer(3, 0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rx_buf[k] !== exp_rx[k]) $display("[TB] FAIL read_byte%0d: got %h expected %h", k, rx_buf[k], exp_rx[k]);
            else passed++;
        end
        total++;
        if (stb_count !== exp_stb) $display("[TB] FAIL read_no_stb: got %0d expected %0d", stb_count, exp_stb);
        else passed++;
        total++;
        if (regs_o !== exp_regs()) $display("[TB] FAIL read_regs: got %h expected %h", regs_o, exp_regs());
        else passed++;
    endtask

    task automatic test_read_wrap();
        tx_buf[0] = 8'h7F;
        tx_buf[1] = 8'hC3;
        tx_buf[2] = 8'h00;
        tx_buf[3] = 8'hFF;
        model_xfer(4);
        spi_xfer(4, 0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rx_buf[k] !== exp_rx[k]) $display("[TB] FAIL wrap_byte%0d: got %h expected %h", k, rx_buf[k], exp_rx[k]);
            else passed++;
        end
    endtask

    task automatic test_abort();
        tx_buf[0] = 8'h81;
        model_xfer(1);
        spi_xfer(1, 5, 8'hFF);
        total++;
        if (regs_o !== exp_regs()) $display("[TB] FAIL abort_regs: got %h expected %h", regs_o, exp_regs());
        else passed++;
        total++;
        if (stb_count !== exp_stb) $display("[TB] FAIL abort_stb: got %0d expected %0d", stb_count, exp_stb);
        else passed++;
        tx_buf[0] = 8'h81;
        tx_buf[1] = 8'hA5;
        model_xfer(2);
        spi_xfer(2, 0, 8'h00);
        total++;
        if (regs_o !== exp_regs()) $display("[TB] FAIL abort_next_regs: got %h expected %h", regs_o, exp_regs());
        else passed++;
        total++;
        if (stb_count !== exp_stb || wr_addr !== exp_last_addr)
            $display("[TB] FAIL abort_next_stb: got %0d/%h expected %0d/%h", stb_count, wr_addr, exp_stb, exp_last_addr);
        else passed++;
    endtask

    task automatic test_reset_abort();
        logic [7:0] r;
        logic m;
        logic [7:0] d;
        d = 8'h5C;
        spi_start();
        spi_byte(8'h80, r);
        for (int j = 0; j < 4; j++) spi_bit(d[7-j], m);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int j = 4; j < 8; j++) spi_bit(d[7-j], m);
        spi_end();
        total++;
        if (regs_o !== exp_regs()) $display("[TB] FAIL rstabort_regs: got %h expected %h", regs_o, exp_regs());
        else passed++;
        total++;
        if (stb_count !== exp_stb) $display("[TB] FAIL rstabort_stb: got %0d expected %0d", stb_count, exp_stb);
        else passed++;
        total++;
        if (busy !== 1'b0 || miso !== 1'b0) $display("[TB] FAIL rstabort_idle: got busy=%b miso=%b expected 0/0", busy, miso);
        else passed++;
        tx_buf[0] = 8'h83;
        tx_buf[1] = 8'h9E;
        model_xfer(2);
        spi_xfer(2, 0, 8'h00);
        total++;
        if (regs_o !== exp_regs() || wr_addr !== exp_last_addr)
            $display("[TB] FAIL rstabort_next: got %h/%h expected %h/%h", regs_o, wr_addr, exp_regs(), exp_last_addr);
        else passed++;
    endtask

    task automatic test_random();
        int sel;
        int nb;
        int extra;
        logic [7:0] ev;
        for (int t = 0; t < 25; t++) begin
            sel = $urandom_range(0, 9);
            tx_buf[0][7] = 1'($urandom_range(0, 1));
            tx_buf[0][6:0] = (sel == 8) ? 7'd127 : (sel == 9) ? 7'd126 : 7'(sel);
            nb = $urandom_range(2, 5);
            for (int k = 1; k < 8; k++) tx_buf[k] = 8'($urandom);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            ev = 8'($urandom);
            model_xfer(nb);
            spi_xfer(nb, extra, ev);
            for (int k = 0; k < nb; k++) begin
                total++;
                if (rx_buf[k] !== exp_rx[k])
                    $display("[TB] FAIL rand%0d_byte%0d cmd=%h: got %h expected %h", t, k, tx_buf[0], rx_buf[k], exp_rx[k]);
                else passed++;
            end
            total++;
            if (regs_o !== exp_regs()) $display("[TB] FAIL rand%0d_regs: got %h expected %h", t, regs_o, exp_regs());
            else passed++;
            total++;
            if (stb_count !== exp_stb || wr_addr !== exp_last_addr)
                $display("[TB] FAIL rand%0d_stb: got %0d/%h expected %0d/%h", t, stb_count, wr_addr, exp_stb, exp_last_addr);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        tx_buf[0] = 8'h80;
        tx_buf[1] = 8'h3C;
        tx_buf[2] = 8'hC7;
        model_xfer(3);
        spi_xfer(3, 0, 8'h00);
        tx_buf[0] = 8'h00;
        tx_buf[1] = 8'h00;
        tx_buf[2] = 8'h00;
        model_xfer(3);
        spi_xfer(3, 0, 8'h00);
        total++;
        if (rx_buf[1] !== exp_rx[1] || rx_buf[2] !== exp_rx[2])
            $display("[TB] FAIL b2b_readback: got %h %h expected %h %h", rx_buf[1], rx_buf[2], exp_rx[1], exp_rx[2]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_write();
        test_read();
        test_read_wrap();
        test_abort();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
